digital_in_event_scheduler: RTL and testbench
=============================================

Name: digital_in_event_scheduler

Overview:
- Sequences capture of the 8 synchronized digital inputs into timestamped events for the host packetizer.
- Two capture modes:
  - change-detect: emit an event when any masked input bit toggles.
  - periodic: emit an event every i_div+1 clocks.
- Events are buffered in a small FIFO and leave through a valid/ready stream.
- Sits between the digital input synchronizer (i_clk domain) and the packet builder.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
TS_W, 32, timestamp width; free-running counter, wraps
DIV_W, 16, width of periodic divider

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  capture enable
i_mode  in  1  0 = change-detect, 1 = periodic
i_mask  in  8  bits participating in change-detect
i_div  in  DIV_W  periodic interval minus 1 (clocks)
i_d  in  8  synchronized digital inputs (i_clk domain)
o_valid  out  1  FIFO head valid
i_ready  in  1  consumer accepts head when o_valid && i_ready
o_data  out  TS_W+8  {timestamp, sample}; sample in bits [7:0]
o_level  out  $clog2(DEPTH)+1  current FIFO occupancy
o_drop_cnt  out  8  events lost to full FIFO, saturating

Behaviour:
- Reset (async assert, sync release) clears everything:
  - o_valid=0, o_data=0, o_level=0, o_drop_cnt=0.
  - Timestamp counter=0, prev=0, divider=0, state=IDLE.
- Timestamp counter ts increments every clock from reset, independent of i_en, and wraps 2^TS_W-1 -> 0.
- State machine IDLE, SNAP, RUN:
  - IDLE: prev <= i_d each cycle; divider held 0; no pushes. Go to SNAP when i_en=1.
  - IDLE->SNAP transition latches i_mode, i_mask and i_div into config registers and clears o_drop_cnt. Config changes during SNAP/RUN are ignored until the next IDLE->SNAP.
  - SNAP (exactly 1 cycle): push {ts, i_d} unconditionally as the initial-state event; prev <= i_d; divider <= 0; go to RUN. If i_en=0 in this cycle, the push still occurs and the next state is IDLE.
  - RUN, change-detect: trigger = ((i_d ^ prev) & mask) != 0; prev <= i_d every cycle. Unmasked toggles update prev silently.
  - RUN, periodic: divider counts 0..div. Trigger when divider==div, then divider <= 0. div=0 triggers every cycle. The first periodic event comes div+1 cycles after the SNAP event.
  - RUN: on trigger, push {ts, i_d} using the current-cycle values. i_en=0 goes to IDLE with no push that cycle.
- Leaving RUN does not flush the FIFO; queued entries continue to drain.
- Latency: an event pushed at edge N is visible as o_valid=1 after edge N if the FIFO was empty (1 cycle from i_d change to o_valid).
- FIFO:
  - Show-ahead: o_data is the head and stays stable while o_valid && !i_ready.
  - Pop when o_valid && i_ready.
  - Simultaneous push and pop is legal at any level, including full (level unchanged, both accepted) and empty (push lands, o_valid next cycle; no bypass).
  - Push with level==DEPTH and no pop: event dropped; o_drop_cnt increments, saturating at 255.
  - Pointers wrap modulo DEPTH; o_level ranges 0..DEPTH.
- o_data holds its last value when o_valid=0; consumers must not sample it then.

Decomposition:
- Shared package: state encoding (IDLE/SNAP/RUN), mode constants MODE_CHANGE=0 and MODE_PERIODIC=1, and the event field offsets (SAMPLE_LSB=0, TS_LSB=8).
- One sub-module, event_fifo: parameterized synchronous show-ahead FIFO (DEPTH, width) with level output. It is reusable by other input-capture blocks.

Test Plan:
- Reset then i_en=1 with i_d=8'hA5, mode 0, mask 8'hFF -> one SNAP event {ts=t0, 8'hA5}. No further events while i_d is static.
- Change-detect, mask 8'h0F: i_d 8'h00 -> 8'h10 -> 8'h11 -> exactly one event, sample 8'h11, timestamp = cycle of the 8'h11 edge; bit 4 toggle ignored.
- Periodic, i_div=3, i_ready=1 -> SNAP event, then events exactly every 4 clocks; timestamp deltas equal 4. i_div=0 -> an event every cycle.
- i_ready=0, periodic div=0, DEPTH=16 -> o_level reaches 16. Then 300 further triggers -> o_drop_cnt saturates at 255 and head o_data is unchanged.
- Full FIFO with i_ready=1 and a trigger in the same cycle -> o_level stays 16, no drop, head advances by one entry.
- i_rst_n pulsed low mid-RUN with 5 entries queued -> o_valid=0, o_level=0 and o_drop_cnt=0 immediately (asynchronously); the next i_en produces a fresh SNAP event.

Source files
------------

// File: rtl/digital_in_event_scheduler_pkg.sv
// Shared types and constants for the digital input event scheduler.
// Event layout: {timestamp, sample}, sample in the low byte.
package digital_in_event_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic MODE_CHANGE   = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int SAMPLE_LSB = 0;
  localparam int TS_LSB     = 8;

endpackage

// File: rtl/digital_in_event_scheduler_if.sv
// Event output stream: show-ahead head with valid/ready handshake.
// The master drives the head, the slave drives ready.
interface digital_in_event_scheduler_if #(
  parameter int W = 40
);

  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_data;

  modport master (
    output o_valid,
    output o_data,
    input  i_ready
  );

  modport slave (
    input  o_valid,
    input  o_data,
    output i_ready
  );

endinterface

// File: rtl/digital_in_event_scheduler_event_fifo.sv
// Synchronous show-ahead FIFO with registered head and level.
// Push and pop in the same cycle are accepted even when full.
module event_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 40,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  output logic [LW-1:0] o_level,
  output logic          o_drop
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [LW-1:0] level_q;
  logic [W-1:0]  head_q;
  logic [W-1:0]  head_d;
  logic          full;
  logic          pop;
  logic          wr;

  assign pop  = i_pop && (level_q != '0);
  assign full = (level_q == LW'(DEPTH));
  assign wr   = i_push && (!full || pop);

  // Head is registered so it holds its last value once the FIFO empties.
  always_comb begin
    head_d = head_q;
    if (pop) begin
      if (level_q > LW'(1)) begin
        head_d = mem_q[rptr_q + AW'(1)];
      end else if (wr) begin
        head_d = i_data;
      end
    end else if ((level_q == '0) && wr) begin
      head_d = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr) begin
      mem_q[wptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      head_q  <= head_d;
      level_q <= level_q + LW'(wr) - LW'(pop);
      if (wr) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
    end
  end

  assign o_data  = head_q;
  assign o_valid = (level_q != '0);
  assign o_level = level_q;
  assign o_drop  = i_push && !wr;

endmodule

// File: rtl/digital_in_event_scheduler.sv
// Turns synchronized digital inputs into timestamped events,
// either on masked bit changes or at a fixed clock interval.
module digital_in_event_scheduler
  import digital_in_event_scheduler_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 32,
  parameter int DIV_W = 16,
  localparam int LW   = $clog2(DEPTH) + 1,
  localparam int EW   = TS_W + 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_mode,
  input  logic [7:0]           i_mask,
  input  logic [DIV_W-1:0]     i_div,
  input  logic [7:0]           i_d,
  digital_in_event_scheduler_if.master evt,
  output logic [LW-1:0]        o_level,
  output logic [7:0]           o_drop_cnt
);

  state_e           state_q;
  logic [TS_W-1:0]  ts_q;
  logic [7:0]       prev_q;
  logic [7:0]       mask_q;
  logic [7:0]       drop_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] divcfg_q;
  logic             mode_q;
  logic             trig;
  logic             push;
  logic             drop;
  logic [EW-1:0]    ev;

  always_comb begin
    ev = '0;
    ev[TS_LSB +: TS_W]   = ts_q;
    ev[SAMPLE_LSB +: 8]  = i_d;
  end

  always_comb begin
    trig = 1'b0;
    if (mode_q == MODE_PERIODIC) begin
      trig = (div_q == divcfg_q);
    end else begin
      trig = |((i_d ^ prev_q) & mask_q);
    end
  end

  always_comb begin
    push = 1'b0;
    unique case (state_q)
      SNAP:    push = 1'b1;
      RUN:     push = i_en && trig;
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      prev_q   <= '0;
      mask_q   <= '0;
      drop_q   <= '0;
      div_q    <= '0;
      divcfg_q <= '0;
      mode_q   <= MODE_CHANGE;
    end else begin
      ts_q   <= ts_q + TS_W'(1);
      prev_q <= i_d;
      if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
      unique case (state_q)
        IDLE: begin
          div_q <= '0;
          if (i_en) begin
            state_q  <= SNAP;
            mode_q   <= i_mode;
            mask_q   <= i_mask;
            divcfg_q <= i_div;
            drop_q   <= '0;
          end
        end
        SNAP: begin
          div_q   <= '0;
          state_q <= i_en ? RUN : IDLE;
        end
        RUN: begin
          div_q <= trig ? '0 : div_q + DIV_W'(1);
          if (!i_en) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  event_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (ev),
    .i_pop   (evt.i_ready),
    .o_data  (evt.o_data),
    .o_valid (evt.o_valid),
    .o_level (o_level),
    .o_drop  (drop)
  );

  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_digital_in_event_scheduler.sv
// Scoreboard bench for the digital input event scheduler.
// Expected events are queued as stimulus is driven, popped on handshake.
module tb_digital_in_event_scheduler;

  localparam int DEPTH = 16;
  localparam int TS_W  = 32;
  localparam int DIV_W = 16;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             mode;
  logic [7:0]       mask;
  logic [DIV_W-1:0] divv;
  logic [7:0]       d;
  logic [4:0]       level;
  logic [7:0]       drop_cnt;
  logic [TS_W-1:0]  tcnt;

  logic [39:0] exp_q [$];
  int          n_chk;
  int          n_fail;
  int          lvl;
  int          drops;

  digital_in_event_scheduler_if #(.W(40)) evt ();

  digital_in_event_scheduler #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W),
    .DIV_W (DIV_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_mode     (mode),
    .i_mask     (mask),
    .i_div      (divv),
    .i_d        (d),
    .evt        (evt),
    .o_level    (level),
    .o_drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else        tcnt <= tcnt + 1;
  end

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && evt.o_valid && evt.i_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious", 64'(evt.o_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("event", 64'(evt.o_data), 64'(e));
        end
      end
    end
  end

  task automatic cyc(input bit trig);
    bit pop;
    pop = evt.i_ready && (lvl > 0);
    if (trig) begin
      if (lvl < DEPTH || pop) begin
        exp_q.push_back({tcnt, d});
        lvl++;
      end else if (drops < 255) begin
        drops++;
      end
    end
    if (pop) lvl--;
    @(negedge clk);
  endtask

  task automatic start(input logic m, input logic [7:0] mk,
                       input logic [DIV_W-1:0] dv, input logic [7:0] dat);
    en = 1'b0;
    d  = dat;
    cyc(1'b0);
    mode  = m;
    mask  = mk;
    divv  = dv;
    en    = 1'b1;
    drops = 0;
    cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic stop();
    en = 1'b0;
    cyc(1'b0);
  endtask

  task automatic drain(input string tag);
    evt.i_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (lvl == 0 && exp_q.size() == 0) break;
      cyc(1'b0);
    end
    check_eq({tag, "_queue"}, 64'(exp_q.size()), 64'd0);
    check_eq({tag, "_level"}, 64'(level), 64'd0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    lvl = 0;
    drops = 0;
    rst_n = 1'b0;
    en = 1'b0;
    mode = 1'b0;
    mask = 8'h00;
    divv = '0;
    d = 8'h00;
    evt.i_ready = 1'b0;
    #3;
    check_eq("rst_valid", 64'(evt.o_valid), 64'd0);
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt), 64'd0);
    check_eq("rst_data", 64'(evt.o_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    evt.i_ready = 1'b1;
    start(1'b0, 8'hFF, '0, 8'hA5);
    repeat (8) cyc(1'b0);
    stop();
    drain("snap");

    start(1'b0, 8'h0F, '0, 8'h00);
    d = 8'h10;
    cyc(1'b0);
    d = 8'h11;
    cyc(1'b1);
    repeat (4) cyc(1'b0);
    stop();
    drain("change");

    start(1'b1, 8'hFF, 16'd3, 8'h5A);
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 7 + 1);
      cyc((i % 4) == 3);
    end
    stop();
    drain("div3");

    start(1'b1, 8'hFF, 16'd0, 8'h3C);
    for (int i = 0; i < 6; i++) begin
      d = 8'(i + 8'h40);
      cyc(1'b1);
    end
    stop();
    drain("div0");

    evt.i_ready = 1'b0;
    start(1'b1, 8'hFF, 16'd0, 8'h77);
    for (int i = 0; i < 18; i++) begin
      d = 8'(i);
      cyc(1'b1);
    end
    check_eq("full_level", 64'(level), 64'(lvl));
    check_eq("full_drop", 64'(drop_cnt), 64'(drops));
    check_eq("full_head", 64'(evt.o_data), 64'(exp_q[0]));

    evt.i_ready = 1'b1;
    d = 8'hE1;
    cyc(1'b1);
    evt.i_ready = 1'b0;
    check_eq("pp_level", 64'(level), 64'(lvl));
    check_eq("pp_drop", 64'(drop_cnt), 64'(drops));
    check_eq("pp_head", 64'(evt.o_data), 64'(exp_q[0]));

    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom_range(0, 255));
      cyc(1'b1);
    end
    check_eq("sat_drop", 64'(drop_cnt), 64'(drops));
    check_eq("sat_level", 64'(level), 64'(lvl));
    check_eq("sat_head", 64'(evt.o_data), 64'(exp_q[0]));
    stop();
    drain("sat");

    evt.i_ready = 1'b0;
    start(1'b0, 8'hFF, '0, 8'h00);
    for (int i = 0; i < 18; i++) begin
      d = (i % 2 == 0) ? 8'hFF : 8'h00;
      cyc(1'b1);
    end
    evt.i_ready = 1'b1;
    repeat (11) cyc(1'b0);
    evt.i_ready = 1'b0;
    check_eq("pre_rst_level", 64'(level), 64'(lvl));
    check_eq("pre_rst_drop", 64'(drop_cnt), 64'(drops));
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_valid", 64'(evt.o_valid), 64'd0);
    check_eq("async_level", 64'(level), 64'd0);
    check_eq("async_drop", 64'(drop_cnt), 64'd0);
    exp_q.delete();
    lvl = 0;
    drops = 0;
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    evt.i_ready = 1'b1;
    start(1'b0, 8'hFF, '0, 8'h5C);
    repeat (3) cyc(1'b0);
    stop();
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
